// File: rtl/mips_dump_pkg.sv
// Shared types for the MIPS end-of-run state dumper: FSM states, stream
// element kinds, and the saturating counter helper.
package mips_dump_pkg;

  localparam int CNT_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    WATCH,
    D_PC,
    D_REG,
    D_MEM,
    DONE
  } state_e;

  localparam logic [1:0] KIND_PC  = 2'd0;
  localparam logic [1:0] KIND_REG = 2'd1;
  localparam logic [1:0] KIND_MEM = 2'd2;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/mips_halt_detector.sv
// Watches the core PC after start. Raises a one-cycle halt pulse when the PC
// has held one value for HALT_STABLE consecutive cycles (the start cycle
// counts as the first), or a timeout pulse once the cycle budget is spent.
module mips_halt_detector
  import mips_dump_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int HALT_STABLE = 4,
  parameter int TIMEOUT_CYC = 190
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              arm,
  input  logic              watch,
  input  logic [DATA_W-1:0] pc_in,
  output logic              halt,
  output logic              timeout,
  output logic [CNT_W-1:0]  cyc_cnt,
  output logic [DATA_W-1:0] pc_hold
);

  logic [DATA_W-1:0] pc_q, pc_d;
  logic [CNT_W-1:0]  stable_q, stable_d;
  logic [CNT_W-1:0]  cyc_q, cyc_d;

  // Next-state of the PC tracker and the halt/timeout decision for this cycle.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    pc_d     = pc_q;
    stable_d = stable_q;
    cyc_d    = cyc_q;
    halt     = 1'b0;
    timeout  = 1'b0;
    if (arm) begin
      pc_d     = pc_in;
      stable_d = CNT_W'(1);
      cyc_d    = '0;
    end else if (watch) begin
      pc_d     = pc_in;
      stable_d = (pc_in == pc_q) ? sat_inc(stable_q) : CNT_W'(1);
      cyc_d    = sat_inc(cyc_q);
      halt     = (stable_d == CNT_W'(HALT_STABLE));
      // A halt seen in the same cycle as the budget running out wins.
      timeout  = !halt && (cyc_q == CNT_W'(TIMEOUT_CYC - 1));
    end
  end

  // Tracker registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: flops take non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      pc_q     <= '0;
      stable_q <= '0;
      cyc_q    <= '0;
    end else begin
      pc_q     <= pc_d;
      stable_q <= stable_d;
      cyc_q    <= cyc_d;
    end
  end

  assign cyc_cnt = cyc_q;
  assign pc_hold = pc_q;

endmodule

// File: rtl/mips_state_dumper.sv
// End-of-run state dumper: waits for the core to halt (or time out), then
// streams PC, every register and a window of data memory over valid/ready.
module mips_state_dumper
  import mips_dump_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int NUM_REGS    = 32,
  parameter int REG_AW      = 5,
  parameter int DM_AW       = 10,
  parameter int DM_BASE     = 0,
  parameter int DUMP_WORDS  = 12,
  parameter int HALT_STABLE = 4,
  parameter int TIMEOUT_CYC = 190
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] pc_in,
  output logic [REG_AW-1:0] rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic [DM_AW-1:0]  dm_raddr,
  input  logic [DATA_W-1:0] dm_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        out_kind,
  output logic [15:0]       out_index,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done,
  output logic              timed_out,
  output logic [15:0]       cycles
);

  localparam int IDX_W = 16;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              out_valid_q, out_valid_d;
  logic [1:0]        out_kind_q, out_kind_d;
  logic [IDX_W-1:0]  out_index_q, out_index_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              timed_out_q, timed_out_d;
  logic [CNT_W-1:0]  cycles_q, cycles_d;

  logic              arm, halt, timeout;
  logic [CNT_W-1:0]  cyc_cnt;
  logic [DATA_W-1:0] pc_hold;
  logic              can_load, accept;

  assign can_load = !out_valid_q || out_ready;
  assign accept   = out_valid_q && out_ready;

  mips_halt_detector #(
    .DATA_W      (DATA_W),
    .HALT_STABLE (HALT_STABLE),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_halt (
    .clk     (clk),
    .rst_n   (rst_n),
    .arm     (arm),
    .watch   (state_q == WATCH),
    .pc_in   (pc_in),
    .halt    (halt),
    .timeout (timeout),
    .cyc_cnt (cyc_cnt),
    .pc_hold (pc_hold)
  );

  // FSM next state, index counter, read addresses and output-slice loads.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    out_kind_d  = out_kind_q;
    out_index_d = out_index_q;
    out_data_d  = out_data_q;
    timed_out_d = timed_out_q;
    cycles_d    = cycles_q;
    arm         = 1'b0;
    rf_raddr    = '0;
    dm_raddr    = '0;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          arm         = 1'b1;
          state_d     = WATCH;
          timed_out_d = 1'b0;
          cycles_d    = '0;
        end
      end
      WATCH: begin
        if (halt || timeout) begin
          state_d     = D_PC;
          timed_out_d = timeout;
          cycles_d    = sat_inc(cyc_cnt);
        end
      end
      D_PC: begin
        if (can_load) begin
          out_valid_d = 1'b1;
          out_kind_d  = KIND_PC;
          out_index_d = '0;
          out_data_d  = pc_hold;
          state_d     = D_REG;
          idx_d       = '0;
        end
      end
      D_REG: begin
        rf_raddr = idx_q[REG_AW-1:0];
        if (idx_q < IDX_W'(NUM_REGS)) begin
          if (can_load) begin
            out_valid_d = 1'b1;
            out_kind_d  = KIND_REG;
            out_index_d = idx_q;
            out_data_d  = rf_rdata;
            idx_d       = idx_q + IDX_W'(1);
            if (idx_q == IDX_W'(NUM_REGS - 1) && DUMP_WORDS != 0) begin
              state_d = D_MEM;
              idx_d   = '0;
            end
          end
        end else if (accept) begin
          // Last register was the final element: finish on its acceptance.
          out_valid_d = 1'b0;
          state_d     = DONE;
        end
      end
      D_MEM: begin
        dm_raddr = DM_AW'(DM_BASE) + DM_AW'({idx_q, 2'b00});
        if (idx_q < IDX_W'(DUMP_WORDS)) begin
          if (can_load) begin
            out_valid_d = 1'b1;
            out_kind_d  = KIND_MEM;
            out_index_d = idx_q;
            out_data_d  = dm_rdata;
            idx_d       = idx_q + IDX_W'(1);
          end
        end else if (accept) begin
          out_valid_d = 1'b0;
          state_d     = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, index and output-slice registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_kind_q  <= '0;
      out_index_q <= '0;
      out_data_q  <= '0;
      timed_out_q <= 1'b0;
      cycles_q    <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_kind_q  <= out_kind_d;
      out_index_q <= out_index_d;
      out_data_q  <= out_data_d;
      timed_out_q <= timed_out_d;
      cycles_q    <= cycles_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_kind  = out_kind_q;
  assign out_index = out_index_q;
  assign out_data  = out_data_q;
  assign timed_out = timed_out_q;
  assign cycles    = cycles_q;
  assign done      = (state_q == DONE);
  assign busy      = (state_q == WATCH) || (state_q == D_PC) ||
                     (state_q == D_REG) || (state_q == D_MEM);

endmodule

// File: tb/tb_mips_state_dumper.sv
// Scoreboard bench for mips_state_dumper: expected elements are queued when a
// run is launched and popped as the DUT's stream is accepted.
module tb_mips_state_dumper;

  typedef struct packed {
    logic [1:0]  kind;
    logic [15:0] index;
    logic [31:0] data;
  } elem_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_r = 1'b0;
  logic        sel = 1'b0;
  logic        rdy = 1'b0;
  int          rdy_mode = 0;
  logic [31:0] pc_in = '0;

  // dut1: default parameters; dut2: memory window that wraps the address space
  logic [4:0]  rf_raddr1, rf_raddr2;
  logic [9:0]  dm_raddr1, dm_raddr2;
  logic [31:0] rf_rdata1, rf_rdata2, dm_rdata1, dm_rdata2;
  logic        ov1, ov2, busy1, busy2, done1, done2, to1, to2;
  logic [1:0]  kind1, kind2;
  logic [15:0] idx1, idx2, cyc1, cyc2;
  logic [31:0] data1, data2;
  logic        start1, start2;

  int total = 0;
  int bad   = 0;
  elem_t exp_q[$];
  int acc_cnt = 0;
  int valid_cyc = 0;
  int rdy_phase = 0;
  logic  hold_pend = 1'b0;
  elem_t held, cur, e;

  always #5 clk = ~clk;

  function automatic logic [31:0] rf_fn(input logic [4:0] a);
    return 32'h1000_0000 + {27'b0, a} * 32'h0101;
  endfunction

  function automatic logic [31:0] dm_fn(input logic [9:0] a);
    return 32'hD000_0000 | {22'b0, a};
  endfunction

  function automatic logic [31:0] pc_fn(input int mode, input int k);
    if (mode == 0) return (k < 30) ? 32'h100 + 32'(4 * k) : 32'h28;
    return 32'h400 + 32'(4 * k);
  endfunction

  assign rf_rdata1 = rf_fn(rf_raddr1);
  assign rf_rdata2 = rf_fn(rf_raddr2);
  assign dm_rdata1 = dm_fn(dm_raddr1);
  assign dm_rdata2 = dm_fn(dm_raddr2);
  assign start1    = start_r & ~sel;
  assign start2    = start_r & sel;

  mips_state_dumper u_dut (
    .clk(clk), .rst_n(rst_n), .start(start1), .pc_in(pc_in),
    .rf_raddr(rf_raddr1), .rf_rdata(rf_rdata1),
    .dm_raddr(dm_raddr1), .dm_rdata(dm_rdata1),
    .out_valid(ov1), .out_ready(rdy), .out_kind(kind1), .out_index(idx1),
    .out_data(data1), .busy(busy1), .done(done1), .timed_out(to1), .cycles(cyc1)
  );

  mips_state_dumper #(.DM_BASE(32'h3F8), .DUMP_WORDS(4)) u_dut_wrap (
    .clk(clk), .rst_n(rst_n), .start(start2), .pc_in(pc_in),
    .rf_raddr(rf_raddr2), .rf_rdata(rf_rdata2),
    .dm_raddr(dm_raddr2), .dm_rdata(dm_rdata2),
    .out_valid(ov2), .out_ready(rdy), .out_kind(kind2), .out_index(idx2),
    .out_data(data2), .busy(busy2), .done(done2), .timed_out(to2), .cycles(cyc2)
  );

  logic        m_valid, m_done, m_to, m_busy;
  logic [1:0]  m_kind;
  logic [15:0] m_index, m_cyc;
  logic [31:0] m_data;
  assign m_valid = sel ? ov2 : ov1;
  assign m_done  = sel ? done2 : done1;
  assign m_to    = sel ? to2 : to1;
  assign m_busy  = sel ? busy2 : busy1;
  assign m_kind  = sel ? kind2 : kind1;
  assign m_index = sel ? idx2 : idx1;
  assign m_cyc   = sel ? cyc2 : cyc1;
  assign m_data  = sel ? data2 : data1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Consumer: pick out_ready for the coming edge, then score what it accepts.
  always @(negedge clk) begin
    rdy = (rdy_mode == 0) ? 1'b1 : (rdy_phase % 3 == 0);
    rdy_phase++;
    cur = '{kind: m_kind, index: m_index, data: m_data};
    if (hold_pend) begin
      check("hold", {m_valid, cur}, {1'b1, held});
      hold_pend = 1'b0;
    end
    if (m_valid) begin
      valid_cyc++;
      if (rdy) begin
        acc_cnt++;
        if (exp_q.size() == 0) begin
          check("extra_elem", 64'(cur), 64'(0));
        end else begin
          e = exp_q.pop_front();
          check("elem", 64'(cur), 64'(e));
        end
      end else begin
        held      = cur;
        hold_pend = 1'b1;
      end
    end
  end

  task automatic push_expected(input logic [31:0] exp_pc, input int words, input int base);
    exp_q.push_back('{kind: 2'd0, index: 16'd0, data: exp_pc});
    for (int r = 0; r < 32; r++)
      exp_q.push_back('{kind: 2'd1, index: 16'(r), data: rf_fn(5'(r))});
    for (int w = 0; w < words; w++)
      exp_q.push_back('{kind: 2'd2, index: 16'(w), data: dm_fn(10'((base + 4 * w) % 1024))});
  endtask

  // Launch one run, drive the PC per cycle, wait (bounded) for done, check results.
  task automatic run_dump(input string name, input int pc_mode, input logic [31:0] exp_pc,
                          input int exp_cyc, input logic exp_to, input bit inject,
                          input int words, input int base, input bit check_b2b);
    bit seen = 0;
    push_expected(exp_pc, words, base);
    acc_cnt   = 0;
    valid_cyc = 0;
    for (int k = 0; k < 600 && !seen; k++) begin
      @(negedge clk);
      start_r = (k == 0) || (inject && (k == 10 || k == 50));
      pc_in   = pc_fn(pc_mode, k);
      if (k == 1) begin
        check({name, "_armed_busy"}, m_busy, 1);
        check({name, "_armed_done"}, m_done, 0);
        check({name, "_armed_to"}, m_to, 0);
      end
      if (k > 1 && m_done) seen = 1;
    end
    start_r = 1'b0;
    check({name, "_done_seen"}, seen, 1);
    check({name, "_timed_out"}, m_to, exp_to);
    check({name, "_cycles"}, m_cyc, exp_cyc);
    check({name, "_queue_left"}, exp_q.size(), 0);
    check({name, "_accepted"}, acc_cnt, 33 + words);
    if (check_b2b) check({name, "_valid_cycles"}, valid_cyc, 33 + words);
    exp_q.delete();
  endtask

  initial begin
    bit hit = 0;
    #3;
    check("rst_valid", ov1, 0);
    check("rst_busy", busy1, 0);
    check("rst_done", done1, 0);
    check("rst_to", to1, 0);
    check("rst_cycles", cyc1, 0);
    check("rst_rf_raddr", rf_raddr1, 0);
    check("rst_dm_raddr", dm_raddr1, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // halt at 0x28 from cycle 30, full-rate consumer
    rdy_mode = 0;
    run_dump("halt", 0, 32'h28, 33, 1'b0, 1'b0, 12, 0, 1'b1);
    // PC never repeats: forced dump at the budget
    run_dump("timeout", 1, 32'h400 + 32'(4 * 190), 190, 1'b1, 1'b0, 12, 0, 1'b0);
    // stalling consumer plus stray starts in WATCH and D_REG
    rdy_mode = 1;
    run_dump("stall", 0, 32'h28, 33, 1'b0, 1'b1, 12, 0, 1'b0);
    // wrapping memory window on the second instance
    rdy_mode = 0;
    sel = 1'b1;
    run_dump("wrap", 0, 32'h28, 33, 1'b0, 1'b0, 4, 32'h3F8, 1'b1);
    sel = 1'b0;

    // reset mid-D_MEM (word 5 on the port), then a clean restart
    push_expected(32'h28, 12, 0);
    for (int k = 0; k < 300 && !hit; k++) begin
      @(negedge clk);
      start_r = (k == 0);
      pc_in   = pc_fn(0, k);
      if (ov1 && kind1 == 2'd2 && idx1 == 16'd5) hit = 1;
    end
    start_r = 1'b0;
    check("midreset_reached", hit, 1);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_valid", ov1, 0);
    check("midreset_busy", busy1, 0);
    check("midreset_done", done1, 0);
    exp_q.delete();
    hold_pend = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_dump("restart", 0, 32'h28, 33, 1'b0, 1'b0, 12, 0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
